program_checkpoint_monitor: RTL and testbench

Synthesizable, parametrised checkpoint monitor that sits beside the RISC-V core and snoops its instruction-memory output and register-file write port. Each of NUM_CHANNELS channels matches the fetched instruction word against a masked pattern, counts hits, and snapshots a watched register's value at the hit. A halt detector recognises the end-of-program instruction and freezes monitoring. Benches and on-chip debug read checkpoint results from this block instead of probing core internals hierarchically.

---
 rtl/program_checkpoint_monitor.sv | 89 ++++++++
 tb/tb_program_checkpoint_monitor.sv | 120 ++++++++++++
 2 files changed

// File: rtl/program_checkpoint_monitor.sv
// program_checkpoint_monitor: masked instruction-match channels with register snapshots and halt detection
module program_checkpoint_monitor #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 'h13,
  parameter int HALT_REPEAT = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   instr_valid,
  input  logic [DATA_WIDTH-1:0]                  instr_data,
  input  logic                                   rf_we,
  input  logic [REG_ADDR_WIDTH-1:0]              rf_waddr,
  input  logic [DATA_WIDTH-1:0]                  rf_wdata,
  input  logic [NUM_CHANNELS-1:0]                ch_enable,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     ch_pattern,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     ch_mask,
  input  logic [NUM_CHANNELS*REG_ADDR_WIDTH-1:0] ch_watch_addr,
  output logic [NUM_CHANNELS-1:0]                hit,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]    hit_count,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]     snap_data,
  output logic [NUM_CHANNELS-1:0]                snap_valid,
  output logic                                   halted,
  output logic [31:0]                            fetch_count
);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  typedef enum logic [1:0] {RUN, PENDING, HALTED} state_t;
  state_t state;
  logic [RW-1:0] run_len, nxt_len;
  logic active, is_halt, done;
  assign active = state != HALTED;
  assign is_halt = instr_data == HALT_INSTR;
  assign nxt_len = state == RUN ? RW'(1) : run_len + RW'(1);
  assign done = nxt_len == RW'(HALT_REPEAT);
  // halt detector and fetch counter; HALTED freezes everything until reset/clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= RUN;
      run_len <= '0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else if (instr_valid && active) begin
      fetch_count <= &fetch_count ? fetch_count : fetch_count + 32'd1;
      run_len <= is_halt ? nxt_len : '0;
      state <= !is_halt ? RUN : done ? HALTED : PENDING;
      halted <= is_halt && done;
    end
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] pat, msk, shadow, snapv, snap;
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [COUNT_WIDTH-1:0] cnt;
    logic wr, m, hr, sv;
    assign pat = ch_pattern[i*DATA_WIDTH +: DATA_WIDTH];
    assign msk = ch_mask[i*DATA_WIDTH +: DATA_WIDTH];
    assign wa = ch_watch_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign wr = rf_we && rf_waddr == wa && wa != '0;
    assign snapv = wa == '0 ? '0 : wr ? rf_wdata : shadow;
    assign m = instr_valid && ch_enable[i] && active && ~|((instr_data ^ pat) & msk);
    // shadow copy of the watched register; survives clear
    always_ff @(posedge clk) begin
      if (reset) shadow <= '0;
      else if (wr) shadow <= rf_wdata;
    end
    // per-channel hit pulse, saturating count and snapshot
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        hr <= 1'b0;
        cnt <= '0;
        snap <= '0;
        sv <= 1'b0;
      end else begin
        hr <= m;
        if (m) begin
          cnt <= &cnt ? cnt : cnt + COUNT_WIDTH'(1);
          snap <= snapv;
          sv <= 1'b1;
        end
      end
    end
    assign hit[i] = hr;
    assign snap_valid[i] = sv;
    assign hit_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt;
    assign snap_data[i*DATA_WIDTH +: DATA_WIDTH] = snap;
  end
endmodule

// File: tb/tb_program_checkpoint_monitor.sv
// tb_program_checkpoint_monitor: directed vectors with a queued scoreboard
module tb_program_checkpoint_monitor;
  localparam int N = 4, DW = 32, AW = 5, CW = 4;
  logic clk = 0, reset, clear, instr_valid, rf_we;
  logic [DW-1:0] instr_data, rf_wdata;
  logic [AW-1:0] rf_waddr;
  logic [N-1:0] ch_enable, hit, snap_valid;
  logic [N*DW-1:0] ch_pattern, ch_mask, snap_data;
  logic [N*AW-1:0] ch_watch_addr;
  logic [N*CW-1:0] hit_count;
  logic halted;
  logic [31:0] fetch_count;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] h;
    logic [3:0] c;
    logic [31:0] s;
    logic [3:0] sv;
    logic hl;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];
  program_checkpoint_monitor #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
    .COUNT_WIDTH(CW), .HALT_INSTR(32'h13), .HALT_REPEAT(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .instr_valid(instr_valid), .instr_data(instr_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ch_enable(ch_enable),
    .ch_pattern(ch_pattern), .ch_mask(ch_mask), .ch_watch_addr(ch_watch_addr), .hit(hit),
    .hit_count(hit_count), .snap_data(snap_data), .snap_valid(snap_valid), .halted(halted),
    .fetch_count(fetch_count));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hit", 32'(hit), 32'(e.h));
      chk("hit_count", 32'(hit_count[e.ch*CW +: CW]), 32'(e.c));
      chk("snap_data", snap_data[e.ch*DW +: DW], e.s);
      chk("snap_valid", 32'(snap_valid), 32'(e.sv));
      chk("halted", 32'(halted), 32'(e.hl));
      chk("fetch_count", fetch_count, e.fc);
    end
  end
  task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] ch, input logic [3:0] h,
                     input logic [3:0] c, input logic [31:0] s, input logic [3:0] sv,
                     input logic hl, input logic [31:0] fc);
    instr_valid = v;
    instr_data = d;
    @(posedge clk);
    q.push_back('{ch, h, c, s, sv, hl, fc});
    @(negedge clk);
    instr_valid = 0;
    rf_we = 0;
    clear = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end
  initial begin
    reset = 1; clear = 0; instr_valid = 0; instr_data = 0;
    rf_we = 0; rf_waddr = 0; rf_wdata = 0; ch_enable = 4'b0111;
    ch_pattern = {32'h0, 32'h00B00093, 32'h00000063, 32'h00520e63};
    ch_mask = {32'h0, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFFFF};
    ch_watch_addr = {5'd0, 5'd6, 5'd6, 5'd5};
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    rf_we = 1; rf_waddr = 5; rf_wdata = 7;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h00520e63, 0, 4'b0011, 1, 7, 4'b0011, 0, 1);
    clear = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h00e68463, 1, 4'b0010, 1, 0, 4'b0010, 0, 1);
    cyc(1, 32'h0263c263, 1, 4'b0010, 2, 0, 4'b0010, 0, 2);
    cyc(1, 32'h00000033, 1, 4'b0000, 2, 0, 4'b0010, 0, 3);
    rf_we = 1; rf_waddr = 6; rf_wdata = 21;
    cyc(1, 32'h00B00093, 2, 4'b0100, 1, 21, 4'b0110, 0, 4);
    ch_enable = 4'b1111; rf_we = 1; rf_waddr = 0; rf_wdata = 99;
    cyc(1, 32'h00000033, 3, 4'b1000, 1, 0, 4'b1110, 0, 5);
    ch_enable = 4'b0111;
    cyc(1, 32'h00B00093, 2, 4'b0100, 2, 21, 4'b1110, 0, 6);
    ch_enable = 4'b1000; clear = 1;
    cyc(0, 0, 3, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h13, 3, 4'b1000, 1, 0, 4'b1000, 0, 1);
    cyc(1, 32'h33, 3, 4'b1000, 2, 0, 4'b1000, 0, 2);
    cyc(1, 32'h13, 3, 4'b1000, 3, 0, 4'b1000, 0, 3);
    cyc(0, 0, 3, 4'b0000, 3, 0, 4'b1000, 0, 3);
    cyc(1, 32'h13, 3, 4'b1000, 4, 0, 4'b1000, 1, 4);
    ch_enable = 4'b1001;
    cyc(1, 32'h00520e63, 0, 4'b0000, 0, 0, 4'b1000, 1, 4);
    cyc(1, 32'h13, 3, 4'b0000, 4, 0, 4'b1000, 1, 4);
    ch_enable = 4'b0010; clear = 1;
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      cyc(1, 32'h00e68463, 1, 4'b0010, k > 15 ? 4'd15 : 4'(k), 21, 4'b0010, 0, 32'(k));
    clear = 1;
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h13, 1, 0, 0, 0, 0, 0, 1);
    reset = 1;
    cyc(1, 32'h13, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc(1, 32'h13, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h13, 1, 0, 0, 0, 0, 1, 2);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
